alu1_sched: RTL and testbench

- Shares one Alu1 instance (WIDTH-bit, ALU1_CMD_WIDTH-bit command) between NREQ requesters.
- Each requester issues operations over a valid/ready request channel.
- Round-robin arbitration picks one requester and registers its command and operands into the ALU.
- The block captures the result and returns it on a single shared response channel, tagged with the requester ID.

---
 rtl/alu1_sched.sv | 177 +++++++++++++++++
 tb/tb_alu1_sched.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu1_sched.sv
// Round-robin scheduler sharing one Alu1 between NREQ valid/ready requesters, with a tagged shared response.
// Define ALU1_SCHED_STATS_EN to add per-requester grant counters and an error-response counter.

package alu1_pkg;
  localparam int ALU1_CMD_WIDTH   = 4;
  localparam int ALU1_NR_COMMANDS = 8;

  localparam logic [ALU1_CMD_WIDTH-1:0] ALU1_ADD = 4'd0;
  localparam logic [ALU1_CMD_WIDTH-1:0] ALU1_SUB = 4'd1;
  localparam logic [ALU1_CMD_WIDTH-1:0] ALU1_AND = 4'd2;
  localparam logic [ALU1_CMD_WIDTH-1:0] ALU1_OR  = 4'd3;
  localparam logic [ALU1_CMD_WIDTH-1:0] ALU1_XOR = 4'd4;
  localparam logic [ALU1_CMD_WIDTH-1:0] ALU1_SLL = 4'd5;
  localparam logic [ALU1_CMD_WIDTH-1:0] ALU1_SRL = 4'd6;
  localparam logic [ALU1_CMD_WIDTH-1:0] ALU1_SLTU = 4'd7;
endpackage

module Alu1
  import alu1_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [ALU1_CMD_WIDTH-1:0] cmd,
  input  logic [WIDTH-1:0]          in1,
  input  logic [WIDTH-1:0]          in2,
  output logic [WIDTH-1:0]          result
);
  localparam int SHW = $clog2(WIDTH);

  always_comb begin
    result = '0;
    case (cmd)
      ALU1_ADD:  result = in1 + in2;
      ALU1_SUB:  result = in1 - in2;
      ALU1_AND:  result = in1 & in2;
      ALU1_OR:   result = in1 | in2;
      ALU1_XOR:  result = in1 ^ in2;
      ALU1_SLL:  result = in1 << in2[SHW-1:0];
      ALU1_SRL:  result = in1 >> in2[SHW-1:0];
      ALU1_SLTU: result = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      default:   result = '0;
    endcase
  end
endmodule

module alu1_sched
  import alu1_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int NREQ  = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NREQ-1:0]                req_valid,
  output logic [NREQ-1:0]                req_ready,
  input  logic [NREQ*ALU1_CMD_WIDTH-1:0] req_cmd,
  input  logic [NREQ*WIDTH-1:0]          req_in1,
  input  logic [NREQ*WIDTH-1:0]          req_in2,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [IDW-1:0]                 rsp_id,
  output logic [WIDTH-1:0]               rsp_data,
`ifdef ALU1_SCHED_STATS_EN
  output logic [NREQ*32-1:0]             grant_cnt,
  output logic [31:0]                    err_cnt,
  output logic                           rsp_err
`else
  output logic                           rsp_err
`endif
);
  localparam int CW = ALU1_CMD_WIDTH;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state, next_state;
  logic [IDW-1:0]    last;
  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    grant_id;
  logic              grant_any;
  logic [CW-1:0]     op_cmd;
  logic [WIDTH-1:0]  op_in1, op_in2;
  logic [IDW-1:0]    op_id;
  logic              op_err;
  logic [WIDTH-1:0]  alu_out;

  Alu1 #(.WIDTH(WIDTH)) u_alu (
    .cmd    (op_cmd),
    .in1    (op_in1),
    .in2    (op_in2),
    .result (alu_out)
  );

  assign op_err = (op_cmd >= CW'(ALU1_NR_COMMANDS));

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!grant_any && req_valid[(int'(last) + k) % NREQ]) begin
        grant_any = 1'b1;
        grant_id  = IDW'((int'(last) + k) % NREQ);
      end
    end
    grant[grant_id] = grant_any;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_any) next_state = EXEC;
      EXEC:    next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) ? grant : '0;
  end

  // Operand capture and response registers; the ALU only ever sees the op registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last      <= IDW'(NREQ - 1);
      op_cmd    <= '0;
      op_in1    <= '0;
      op_in2    <= '0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant_any) begin
          op_cmd <= req_cmd[int'(grant_id)*CW +: CW];
          op_in1 <= req_in1[int'(grant_id)*WIDTH +: WIDTH];
          op_in2 <= req_in2[int'(grant_id)*WIDTH +: WIDTH];
          op_id  <= grant_id;
          last   <= grant_id;
        end
        EXEC: begin
          rsp_valid <= 1'b1;
          rsp_id    <= op_id;
          rsp_err   <= op_err;
          rsp_data  <= op_err ? '0 : alu_out;
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef ALU1_SCHED_STATS_EN
  // Saturating statistics, counted at the request handshake and at response creation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (state == IDLE && grant_any &&
          grant_cnt[int'(grant_id)*32 +: 32] != 32'hFFFF_FFFF)
        grant_cnt[int'(grant_id)*32 +: 32] <= grant_cnt[int'(grant_id)*32 +: 32] + 32'd1;
      if (state == EXEC && op_err && err_cnt != 32'hFFFF_FFFF)
        err_cnt <= err_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_alu1_sched.sv
// Scoreboard bench for alu1_sched: directed scenarios plus randomized traffic against a behavioural model.
// Stats checks are compiled in when ALU1_SCHED_STATS_EN is defined.

module tb_alu1_sched;
  import alu1_pkg::*;

  localparam int WIDTH = 64;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int CW    = ALU1_CMD_WIDTH;

  typedef struct {
    int          id;
    logic [63:0] data;
    bit          err;
    int          due;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*CW-1:0]   req_cmd = '0;
  logic [NREQ*WIDTH-1:0] req_in1 = '0;
  logic [NREQ*WIDTH-1:0] req_in2 = '0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [IDW-1:0]       rsp_id;
  logic [WIDTH-1:0]     rsp_data;
  logic                 rsp_err;
`ifdef ALU1_SCHED_STATS_EN
  logic [NREQ*32-1:0]   grant_cnt;
  logic [31:0]          err_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  exp_t sbq[$];
  int gLog[$];
  int gCyc[$];
  int modelLast = NREQ - 1;
  int modelGrants[NREQ];
  int modelErrs = 0;
  bit busy = 0;
  bit pendAccept = 0;
  bit pendRspDone = 0;
  bit prevValid = 0;
  logic [NREQ-1:0] acceptedMask = '0;

  alu1_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .req_in1   (req_in1),
    .req_in2   (req_in2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
`ifdef ALU1_SCHED_STATS_EN
    .grant_cnt (grant_cnt),
    .err_cnt   (err_cnt),
`endif
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  // Reference ALU from the command table: plain arithmetic on 64-bit values.
  function automatic logic [63:0] refAlu(int cmd, logic [63:0] a, logic [63:0] b);
    case (cmd)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a << b[5:0];
      6: return a >> b[5:0];
      7: return (a < b) ? 64'd1 : 64'd0;
      default: return 64'd0;
    endcase
  endfunction

  task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) busy = 0;
    else begin
      if (pendAccept)  busy = 1;
      if (pendRspDone) busy = 0;
    end
    pendAccept  = 0;
    pendRspDone = 0;
  end

  // Request-side model: predicts the round-robin winner and pushes the expected response.
  always @(negedge clk) begin
    if (!rst_n) begin
      modelLast = NREQ - 1;
      modelErrs = 0;
      for (int i = 0; i < NREQ; i++) modelGrants[i] = 0;
      acceptedMask = '0;
    end else begin
      int w;
      logic [NREQ-1:0] expReady;
      w = -1;
      for (int k = 1; k <= NREQ; k++)
        if (w < 0 && req_valid[(modelLast + k) % NREQ]) w = (modelLast + k) % NREQ;
      expReady = '0;
      if (!busy && w >= 0) expReady[w] = 1'b1;
      checkOutput("req_ready", 64'(req_ready), 64'(expReady));
      acceptedMask = req_valid & req_ready;
      if (!busy && w >= 0) begin
        exp_t e;
        int c;
        c = int'(req_cmd[w*CW +: CW]);
        e.id   = w;
        e.err  = (c >= ALU1_NR_COMMANDS);
        e.data = e.err ? 64'd0 : refAlu(c, req_in1[w*WIDTH +: WIDTH], req_in2[w*WIDTH +: WIDTH]);
        e.due  = cyc + 2;
        sbq.push_back(e);
        pendAccept = 1;
        modelLast = w;
        modelGrants[w]++;
        if (e.err) modelErrs++;
        gLog.push_back(w);
        gCyc.push_back(cyc);
      end
    end
  end

  // Response monitor: pops and compares whenever the DUT presents a response.
  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
      prevValid = 0;
    end else begin
      if (sbq.size() > 0 && !rsp_valid && cyc == sbq[0].due)
        checkOutput("rsp_valid_at_due", 64'(rsp_valid), 64'd1);
      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_rsp: got rsp_valid=1 id=%0d, expected no response (cycle %0d)", rsp_id, cyc);
        end else begin
          if (!prevValid) checkOutput("rsp_latency", 64'(cyc), 64'(sbq[0].due));
          checkOutput("rsp_id", 64'(rsp_id), 64'(sbq[0].id));
          checkOutput("rsp_data", rsp_data, sbq[0].data);
          checkOutput("rsp_err", 64'(rsp_err), 64'(sbq[0].err));
          if (rsp_ready) begin
            void'(sbq.pop_front());
            pendRspDone = 1;
          end
        end
      end
      prevValid = rsp_valid;
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acceptedMask;
  endtask

  task automatic setPayload(int i, int cmd, logic [63:0] a, logic [63:0] b);
    req_cmd[i*CW +: CW]       = CW'(cmd);
    req_in1[i*WIDTH +: WIDTH] = a;
    req_in2[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic applyStimulus(int i, int cmd, logic [63:0] a, logic [63:0] b);
    setPayload(i, cmd, a, b);
    req_valid[i] = 1'b1;
  endtask

  task automatic waitAccept(int i, int budget);
    for (int n = 0; n < budget; n++) begin
      stepCycle();
      if (!req_valid[i]) return;
    end
    checks++;
    failures++;
    $display("[TB] FAIL accept_timeout: requester %0d still waiting, expected grant within %0d cycles", i, budget);
    req_valid[i] = 1'b0;
  endtask

  task automatic waitDrain(int budget);
    for (int n = 0; n < budget; n++) begin
      if (req_valid == '0 && sbq.size() == 0 && !busy) return;
      stepCycle();
    end
    checks++;
    failures++;
    $display("[TB] FAIL drain_timeout: pending=%0d valid=%0b, expected idle within %0d cycles", sbq.size(), req_valid, budget);
    req_valid = '0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    req_valid = '0;
    stepCycle();
    stepCycle();
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_rsp_id", 64'(rsp_id), 64'd0);
    checkOutput("reset_rsp_data", rsp_data, 64'd0);
    checkOutput("reset_rsp_err", 64'(rsp_err), 64'd0);
    checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    doReset();

    // Single ADD from requester 0.
    rsp_ready = 1'b1;
    applyStimulus(0, 0, 64'd5, 64'd7);
    waitAccept(0, 10);
    waitDrain(20);

    // All four requesting continuously: strict rotation, one grant every 3 cycles.
    gLog.delete();
    gCyc.delete();
    for (int i = 0; i < NREQ; i++) setPayload(i, i, 64'(100 + i), 64'(3 * i + 1));
    req_valid = '1;
    for (int n = 0; n < 17; n++) begin
      stepCycle();
      req_valid = '1;
    end
    waitDrain(60);
    if (gLog.size() >= 6) begin
      for (int k = 0; k < 6; k++) begin
        checkOutput("rr_order", 64'(gLog[k]), 64'((k + 1) % NREQ));
        if (k > 0) checkOutput("rr_spacing", 64'(gCyc[k] - gCyc[k-1]), 64'd3);
      end
    end else checkOutput("rr_grant_count", 64'(gLog.size()), 64'd6);

    // Backpressure: wrapping ADD held in RESP while requester 2 waits.
    rsp_ready = 1'b0;
    applyStimulus(0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    waitAccept(0, 10);
    applyStimulus(2, 1, 64'd50, 64'd8);
    for (int n = 0; n < 10; n++) stepCycle();
    checkOutput("bp_req2_waiting", 64'(req_valid[2]), 64'd1);
    rsp_ready = 1'b1;
    waitDrain(20);

    // Out-of-range command.
    doReset();
    applyStimulus(1, ALU1_NR_COMMANDS, 64'd9, 64'd9);
    waitAccept(1, 10);
    waitDrain(20);
`ifdef ALU1_SCHED_STATS_EN
    checkOutput("err_cnt_bad_cmd", 64'(err_cnt), 64'd1);
`endif

    // Reset while the op is in EXEC: no response, pointer back to requester 0.
    applyStimulus(3, 0, 64'd1, 64'd2);
    waitAccept(3, 10);
    rst_n = 1'b0;
    stepCycle();
    rst_n = 1'b1;
    gLog.delete();
    gCyc.delete();
    req_valid = '1;
    waitDrain(60);
    if (gLog.size() > 0) checkOutput("post_reset_first_grant", 64'(gLog[0]), 64'd0);
    else checkOutput("post_reset_grant_count", 64'(gLog.size()), 64'd4);

    // Grant statistics: six grants to requester 1, two to requester 3.
    doReset();
    for (int n = 0; n < 6; n++) begin
      applyStimulus(1, 2, 64'(n), 64'hF0);
      waitAccept(1, 10);
    end
    for (int n = 0; n < 2; n++) begin
      applyStimulus(3, 4, 64'(n), 64'h55);
      waitAccept(3, 10);
    end
    waitDrain(20);
`ifdef ALU1_SCHED_STATS_EN
    checkOutput("grant_cnt0", 64'(grant_cnt[0 +: 32]), 64'd0);
    checkOutput("grant_cnt1", 64'(grant_cnt[32 +: 32]), 64'd6);
    checkOutput("grant_cnt2", 64'(grant_cnt[64 +: 32]), 64'd0);
    checkOutput("grant_cnt3", 64'(grant_cnt[96 +: 32]), 64'd2);
`endif

    // Randomized traffic with random backpressure and payload churn while waiting.
    for (int n = 0; n < 600; n++) begin
      stepCycle();
      for (int i = 0; i < NREQ; i++) begin
        setPayload(i, $urandom_range(0, 9), {$urandom, $urandom}, {$urandom, $urandom});
        if (!req_valid[i] && $urandom_range(0, 2) == 0) req_valid[i] = 1'b1;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    rsp_ready = 1'b1;
    waitDrain(200);
`ifdef ALU1_SCHED_STATS_EN
    for (int i = 0; i < NREQ; i++)
      checkOutput("grant_cnt_model", 64'(grant_cnt[i*32 +: 32]), 64'(modelGrants[i]));
    checkOutput("err_cnt_model", 64'(err_cnt), 64'(modelErrs));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "[TB] global timeout");
  end
endmodule
